regfile_param: RTL and testbench

Parametrised integer register file for the rv32i core's decode stage: two combinational read ports, one synchronous write port, hardwired zero register. Successor to the fixed 32×32 file, generalised in data width and depth. Adds a hardware clear sequencer that zeroes every entry after reset, with a `busy` flag the pipeline stalls on. Adds an optional same-cycle write-to-read bypass.

---
 rtl/regfile_param.sv | 113 +++++++++++
 tb/tb_regfile_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised XLEN x NREGS register file with post-reset clear sequencer
// Optional same-cycle write-to-read bypass enabled by defining RF_BYPASS_EN.
module regfile_param #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            reg_write,
    input  logic [AW-1:0]   write_reg,
    input  logic [XLEN-1:0] write_data,
    output logic            busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   ptr_nxt;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // The clear sequencer and the architectural write share the single array write port.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        we        = 1'b0;
        waddr     = write_reg;
        wdata     = write_data;
        case (state)
            CLEAR: begin
                we      = 1'b1;
                waddr   = ptr;
                wdata   = '0;
                ptr_nxt = ptr + AW'(1);
                if (ptr == LAST) begin
                    state_nxt = READY;
                    ptr_nxt   = '0;
                end
            end
            READY: begin
                if (reg_write && (write_reg != '0)) begin
                    we = 1'b1;
                end
            end
            default: begin
                state_nxt = CLEAR;
                ptr_nxt   = '0;
            end
        endcase
        if (rst) begin
            we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign busy = (state != READY);

`ifdef RF_BYPASS_EN
    logic wr_live;
    assign wr_live = (state == READY) && reg_write && (write_reg != '0);
`endif

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (!busy && (rs1 != '0)) begin
            rd1 = mem[rs1];
`ifdef RF_BYPASS_EN
            if (wr_live && (write_reg == rs1)) begin
                rd1 = write_data;
            end
`endif
        end
        if (!busy && (rs2 != '0)) begin
            rd2 = mem[rs2];
`ifdef RF_BYPASS_EN
            if (wr_live && (write_reg == rs2)) begin
                rd2 = write_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - scoreboard bench for regfile_param (XLEN=32, NREGS=32)
module tb_regfile_param;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            reg_write;
    logic [AW-1:0]   write_reg;
    logic [XLEN-1:0] write_data;
    logic            busy;

    typedef struct {
        logic [XLEN-1:0] e1;
        logic [XLEN-1:0] e2;
        string           name;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_param #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd1        (rd1),
        .rd2        (rd2),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .busy       (busy)
    );

    task automatic test_reset;
        int edges;
        exp_t e;
        @(negedge clk);
        rst = 1'b1; reg_write = 1'b0; rs1 = 5'd5; rs2 = 5'd31;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL reset_busy got=%b exp=1", busy);
        end
        sb.push_back('{32'h0, 32'h0, "reset_rd"});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd1 !== e.e1 || rd2 !== e.e2) begin
            failures++; $display("FAIL %s got=%h/%h exp=%h/%h", e.name, rd1, rd2, e.e1, e.e2);
        end
        rst = 1'b0;
        edges = 0;
        while (busy && edges < 100) begin
            @(posedge clk); edges++;
            @(negedge clk);
        end
        checks++;
        if (edges != NREGS || busy !== 1'b0) begin
            failures++; $display("FAIL clear_len got=%0d busy=%b exp=%0d", edges, busy, NREGS);
        end
        for (int i = 0; i < NREGS; i++) begin
            @(negedge clk);
            rs1 = AW'(i); rs2 = AW'(NREGS - 1 - i);
            sb.push_back('{32'h0, 32'h0, "clear_rd"});
            #1;
            e = sb.pop_front();
            checks++;
            if (rd1 !== e.e1 || rd2 !== e.e2) begin
                failures++; $display("FAIL %s[%0d] got=%h/%h exp=%h/%h", e.name, i, rd1, rd2, e.e1, e.e2);
            end
        end
    endtask

    task automatic test_write_read;
        exp_t e;
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
        @(negedge clk);
        write_reg = 5'd31; write_data = 32'h12345678;
        @(negedge clk);
        reg_write = 1'b0; rs1 = 5'd5; rs2 = 5'd31;
        sb.push_back('{32'hDEADBEEF, 32'h12345678, "write_read"});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd1 !== e.e1 || rd2 !== e.e2) begin
            failures++; $display("FAIL %s got=%h/%h exp=%h/%h", e.name, rd1, rd2, e.e1, e.e2);
        end
    endtask

    task automatic test_zero_reg;
        exp_t e;
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd0;
        sb.push_back('{32'h0, 32'h0, "zero_wr_cycle"});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd1 !== e.e1 || rd2 !== e.e2) begin
            failures++; $display("FAIL %s got=%h/%h exp=%h/%h", e.name, rd1, rd2, e.e1, e.e2);
        end
        @(negedge clk);
        reg_write = 1'b0; rs2 = 5'd5;
        sb.push_back('{32'h0, 32'hDEADBEEF, "zero_next_cycle"});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd1 !== e.e1 || rd2 !== e.e2) begin
            failures++; $display("FAIL %s got=%h/%h exp=%h/%h", e.name, rd1, rd2, e.e1, e.e2);
        end
    endtask

    task automatic test_bypass;
        exp_t e;
        logic [XLEN-1:0] same;
`ifdef RF_BYPASS_EN
        same = 32'hCAFEF00D;
`else
        same = 32'h00000001;
`endif
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h1;
        @(negedge clk);
        write_data = 32'hCAFEF00D; rs1 = 5'd9; rs2 = 5'd9;
        sb.push_back('{same, same, "bypass_wr_cycle"});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd1 !== e.e1 || rd2 !== e.e2) begin
            failures++; $display("FAIL %s got=%h/%h exp=%h/%h", e.name, rd1, rd2, e.e1, e.e2);
        end
        @(negedge clk);
        reg_write = 1'b0;
        sb.push_back('{32'hCAFEF00D, 32'hCAFEF00D, "bypass_next_cycle"});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd1 !== e.e1 || rd2 !== e.e2) begin
            failures++; $display("FAIL %s got=%h/%h exp=%h/%h", e.name, rd1, rd2, e.e1, e.e2);
        end
    endtask

    task automatic test_write_during_clear;
        int edges;
        exp_t e;
        @(negedge clk);
        rst = 1'b1; reg_write = 1'b1; write_reg = 5'd3; write_data = 32'hAAAA5555;
        rs1 = 5'd3; rs2 = 5'd9;
        @(negedge clk);
        rst = 1'b0;
        edges = 0;
        while (busy && edges < 100) begin
            sb.push_back('{32'h0, 32'h0, "busy_rd"});
            #1;
            e = sb.pop_front();
            checks++;
            if (rd1 !== e.e1 || rd2 !== e.e2) begin
                failures++; $display("FAIL %s[%0d] got=%h/%h exp=%h/%h", e.name, edges, rd1, rd2, e.e1, e.e2);
            end
            @(posedge clk); edges++;
            @(negedge clk);
        end
        reg_write = 1'b0;
        checks++;
        if (edges != NREGS || busy !== 1'b0) begin
            failures++; $display("FAIL wdc_clear_len got=%0d busy=%b exp=%0d", edges, busy, NREGS);
        end
        sb.push_back('{32'h0, 32'h0, "wdc_r3_dropped"});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd1 !== e.e1 || rd2 !== e.e2) begin
            failures++; $display("FAIL %s got=%h/%h exp=%h/%h", e.name, rd1, rd2, e.e1, e.e2);
        end
    endtask

    task automatic test_reset_mid_clear;
        int edges;
        exp_t e;
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd7; write_data = 32'h55;
        @(negedge clk);
        reg_write = 1'b0; rs1 = 5'd7; rs2 = 5'd7;
        sb.push_back('{32'h55, 32'h55, "r7_written"});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd1 !== e.e1 || rd2 !== e.e2) begin
            failures++; $display("FAIL %s got=%h/%h exp=%h/%h", e.name, rd1, rd2, e.e1, e.e2);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{32'h0, 32'h0, "r7_gated_busy"});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd1 !== e.e1 || rd2 !== e.e2) begin
            failures++; $display("FAIL %s got=%h/%h exp=%h/%h", e.name, rd1, rd2, e.e1, e.e2);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL mid_clear_busy got=%b exp=1", busy);
        end
        edges = 0;
        while (busy && edges < 100) begin
            @(posedge clk); edges++;
            @(negedge clk);
        end
        checks++;
        if (edges != NREGS || busy !== 1'b0) begin
            failures++; $display("FAIL mid_clear_len got=%0d busy=%b exp=%0d", edges, busy, NREGS);
        end
        sb.push_back('{32'h0, 32'h0, "r7_cleared"});
        #1;
        e = sb.pop_front();
        checks++;
        if (rd1 !== e.e1 || rd2 !== e.e2) begin
            failures++; $display("FAIL %s got=%h/%h exp=%h/%h", e.name, rd1, rd2, e.e1, e.e2);
        end
    endtask

    initial begin
        rst = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0; rs1 = '0; rs2 = '0;
        test_reset;
        test_write_read;
        test_zero_reg;
        test_bypass;
        test_write_during_clear;
        test_reset_mid_clear;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
